// File: rtl/jtshouse_cus30_arb_pkg.sv
// Shared types and constants for the CUS30 port arbiter.
package jtshouse_cus30_arb_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, ACK} arb_state_t;

  localparam logic [1:0] REQ_MAIN = 2'd0;
  localparam logic [1:0] REQ_SUB  = 2'd1;
  localparam logic [1:0] REQ_SND  = 2'd2;

  localparam logic [2:0] STSEL_GNT_M = 3'd0;
  localparam logic [2:0] STSEL_GNT_S = 3'd1;
  localparam logic [2:0] STSEL_GNT_A = 3'd2;
  localparam logic [2:0] STSEL_CNT_M = 3'd3;
  localparam logic [2:0] STSEL_CNT_S = 3'd4;
  localparam logic [2:0] STSEL_CNT_A = 3'd5;

endpackage

// File: rtl/jtshouse_cus30_rrsel.sv
// Combinational 3-way round-robin picker: first eligible requester at or after ptr wins.
module jtshouse_cus30_rrsel
  import jtshouse_cus30_arb_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      REQ_SUB: begin
        if      (elig[REQ_SUB])  gnt = 3'b010;
        else if (elig[REQ_SND])  gnt = 3'b100;
        else if (elig[REQ_MAIN]) gnt = 3'b001;
      end
      REQ_SND: begin
        if      (elig[REQ_SND])  gnt = 3'b100;
        else if (elig[REQ_MAIN]) gnt = 3'b001;
        else if (elig[REQ_SUB])  gnt = 3'b010;
      end
      default: begin
        if      (elig[REQ_MAIN]) gnt = 3'b001;
        else if (elig[REQ_SUB])  gnt = 3'b010;
        else if (elig[REQ_SND])  gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/jtshouse_cus30_arb.sv
// Arbiter/sequencer sharing the CUS30 port between main, sub and sound CPUs.
// Optional statistics counters are built when JTSHOUSE_CUS30_ARB_STATS_EN is defined.
module jtshouse_cus30_arb #(
  parameter int RDLAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_cs,
  input  logic        m_rnw,
  input  logic [9:0]  m_addr,
  input  logic [7:0]  m_dout,
  output logic        m_ack,
  input  logic        s_cs,
  input  logic        s_rnw,
  input  logic [9:0]  s_addr,
  input  logic [7:0]  s_dout,
  output logic        s_ack,
  input  logic        a_cs,
  input  logic        a_rnw,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_dout,
  output logic        a_ack,
  output logic [7:0]  rdata,
  output logic        bsel,
  output logic        bcs,
  output logic        brnw,
  output logic [9:0]  baddr,
  output logic [7:0]  bdout,
  output logic        scs,
  output logic        srnw,
  output logic [15:0] saddr,
  output logic [7:0]  sdout,
  input  logic [7:0]  xdin,
  output logic [7:0]  st_dout,
  input  logic [7:0]  debug_bus
);
  import jtshouse_cus30_arb_pkg::*;

  localparam logic [1:0] WAIT_LD = 2'(RDLAT - 1);

  arb_state_t st;
  logic [2:0] cs_v, armed, elig, gnt, cur;
  logic [1:0] ptr, cnt;

  assign cs_v = {a_cs, s_cs, m_cs};
  assign elig = cs_v & armed;

  jtshouse_cus30_rrsel u_rrsel (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (gnt)
  );

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      ptr   <= REQ_MAIN;
      armed <= 3'b111;
      cur   <= 3'b000;
      cnt   <= 2'd0;
      bsel  <= 1'b0;
      bcs   <= 1'b0;
      brnw  <= 1'b0;
      baddr <= 10'd0;
      bdout <= 8'd0;
      scs   <= 1'b0;
      srnw  <= 1'b0;
      saddr <= 16'd0;
      sdout <= 8'd0;
      m_ack <= 1'b0;
      s_ack <= 1'b0;
      a_ack <= 1'b0;
      rdata <= 8'd0;
    end else begin
      m_ack <= 1'b0;
      s_ack <= 1'b0;
      a_ack <= 1'b0;
      bcs   <= 1'b0;
      scs   <= 1'b0;
      // a requester re-arms once its cs has been seen low
      armed <= armed | ~cs_v;
      case (st)
        IDLE: begin
          if (|elig) begin
            cur <= gnt;
            if (gnt[REQ_SND]) begin
              bsel  <= 1'b0;
              scs   <= 1'b1;
              srnw  <= a_rnw;
              saddr <= a_addr;
              sdout <= a_dout;
            end else begin
              bsel  <= 1'b1;
              bcs   <= 1'b1;
              brnw  <= gnt[REQ_MAIN] ? m_rnw  : s_rnw;
              baddr <= gnt[REQ_MAIN] ? m_addr : s_addr;
              bdout <= gnt[REQ_MAIN] ? m_dout : s_dout;
            end
            st <= STROBE;
          end
        end
        // ---- chip select is high during this state ----
        STROBE: begin
          if (RDLAT == 1) begin
            st <= ACK;
          end else begin
            cnt <= WAIT_LD;
            st  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt <= 2'd1) st <= ACK;
          else             cnt <= cnt - 2'd1;
        end
        // ---- xdin valid here; ack lands one clk later ----
        ACK: begin
          rdata <= xdin;
          {a_ack, s_ack, m_ack} <= cur;
          armed <= (armed | ~cs_v) & ~cur;
          case (cur)
            3'b001:  ptr <= REQ_SUB;
            3'b010:  ptr <= REQ_SND;
            default: ptr <= REQ_MAIN;
          endcase
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef JTSHOUSE_CUS30_ARB_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] gcnt [3];
  logic [7:0] ccnt [3];
  logic [2:0] gnt_now;
  logic       unused_dbg;

  assign gnt_now    = (st == IDLE) ? gnt : 3'b000;
  assign unused_dbg = ^debug_bus[7:3];

  // contention = eligible but not granted in that clk
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        gcnt[i] <= 8'd0;
        ccnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (gnt_now[i])              gcnt[i] <= sat_inc(gcnt[i]);
        if (elig[i] && !gnt_now[i])  ccnt[i] <= sat_inc(ccnt[i]);
      end
    end
  end

  always_comb begin
    st_dout = 8'd0;
    case (debug_bus[2:0])
      STSEL_GNT_M: st_dout = gcnt[REQ_MAIN];
      STSEL_GNT_S: st_dout = gcnt[REQ_SUB];
      STSEL_GNT_A: st_dout = gcnt[REQ_SND];
      STSEL_CNT_M: st_dout = ccnt[REQ_MAIN];
      STSEL_CNT_S: st_dout = ccnt[REQ_SUB];
      STSEL_CNT_A: st_dout = ccnt[REQ_SND];
      default:     st_dout = 8'd0;
    endcase
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^debug_bus;
  assign st_dout    = 8'd0;
`endif

endmodule

// File: doc/jtshouse_cus30_arb.md
Name: jtshouse_cus30_arb

Overview:
- Arbiter and sequencer sharing the CUS30 wave-RAM/MMR port between three requesters: main CPU, sub CPU and sound CPU.
- It grants one access at a time and drives the CUS30 bus-select and chip-select signals for exactly one clk per access.
- It waits for the RAM read latency, then returns the read data with a one-cycle ack pulse to the granted requester.
- It sits between the CPU address decoders and jtcus30.

Parameters:
- RDLAT, 1: clk cycles between the CUS30 chip-select cycle and valid xdin (1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- m_cs  in  1  main CPU request (level)
- m_rnw  in  1  main CPU read/not-write
- m_addr  in  10  main CPU address
- m_dout  in  8  main CPU write data
- m_ack  out  1  main CPU access done; read data valid
- s_cs, s_rnw, s_addr[9:0], s_dout[7:0], s_ack: same set for the sub CPU
- a_cs  in  1  sound CPU request
- a_rnw  in  1  sound CPU read/not-write
- a_addr  in  16  sound CPU address
- a_dout  in  8  sound CPU write data
- a_ack  out  1  sound CPU access done
- rdata  out  8  read data, valid while any *_ack is high
- bsel  out  1  to jtcus30: 1 = bus side (main/sub), 0 = sound side
- bcs, brnw, baddr[9:0], bdout[7:0]  out  bus-side signals to jtcus30
- scs, srnw, saddr[15:0], sdout[7:0]  out  sound-side signals to jtcus30
- xdin  in  8  read data from jtcus30
- st_dout  out  8  statistics readout (see Optional Feature)
- debug_bus  in  8  selects the statistics byte

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = main, armed flags = 1.
- Armed flags: each requester has one. It is cleared on that requester's ack and set again once its cs is seen low. An unarmed requester is never granted. This prevents a held cs from repeating the same access.
- Eligibility: a requester is eligible when cs=1 and armed=1.
- States: IDLE, STROBE, WAIT, ACK.
- IDLE: if any requester is eligible, pick the grantee round-robin starting at the pointer (order main -> sub -> snd -> main). Latch its rnw, addr and dout into output registers, set bsel (1 for main/sub, 0 for snd), then go to STROBE. Otherwise stay in IDLE.
- STROBE: assert bcs (main/sub) or scs (snd) for exactly this one cycle; the write completes on this edge. Go to WAIT with a counter loaded to RDLAT-1, or go straight to ACK when RDLAT=1.
- WAIT: count down; at 0 go to ACK.
- ACK: capture xdin into rdata and pulse the grantee's ack for 1 clk. Advance the pointer to the requester after the grantee, then return to IDLE.
- Hold rules: bsel, address, rnw and dout stay stable from STROBE until ACK. bsel is kept unchanged in IDLE (no glitch).
- Latency: grant-to-ack is RDLAT+2 clk. Writes also ack; rdata is then don't-care but still updated.
- Simultaneous requests: round-robin decides; each of three continuous requesters is served once per three accesses.
- Requests ignored mid-access: a requester dropping cs after its grant still gets its ack and its access completes. A requester raising cs mid-access waits for IDLE.
- Reset mid-access: abort immediately, no ack, no further chip-select.
- Unused side: the address/data outputs for the side not in use hold their last values; only its cs is forced to 0.

Optional Feature:
- Macro: JTSHOUSE_CUS30_ARB_STATS_EN.
- With the macro:
  - 8-bit saturating counters per requester: grants, plus clk cycles spent eligible but not granted (contention).
  - st_dout = counter selected by debug_bus[2:0]: 0..2 grants m/s/a, 3..5 contention m/s/a, others 0.
  - Counters are cleared by reset.
- Without the macro: st_dout is tied to 0 and no counters are synthesised.

Decomposition:
- Package jtshouse_cus30_arb_pkg:
  - state enum (IDLE, STROBE, WAIT, ACK)
  - requester index constants REQ_MAIN=0, REQ_SUB=1, REQ_SND=2
  - statistics select constants
- One natural sub-module, jtshouse_cus30_rrsel: a combinational 3-way round-robin picker taking the eligibility vector and the pointer and returning a one-hot grant.

Test Plan:
- Single main write: m_cs=1, m_rnw=0, m_addr=0x105, m_dout=0x3C. Expect bsel=1, bcs high 1 clk with baddr=0x105, bdout=0x3C, m_ack 1 clk, 3 clk after grant with RDLAT=1.
- Sound read: preload RAM 0x020=0xA5, then a_cs=1, a_rnw=1, a_addr=0x0020. Expect bsel=0, scs 1 clk, a_ack with rdata=0xA5.
- Contention: m, s and a all request from the same clk and keep re-requesting. Expect grant order m, s, a, m, s, a and no requester starved.
- Held cs: m_cs held high for 20 clk. Expect exactly one m_ack; a second m_ack only after m_cs goes 0 then 1.
- Reset during WAIT with RDLAT=3: rst pulsed mid-access. Expect no ack, all outputs 0, and normal service afterwards.
- With JTSHOUSE_CUS30_ARB_STATS_EN: 4 main and 2 sub accesses, with sub blocked by main for 3 clk. Expect st_dout=4 at debug_bus=0, 2 at debug_bus=1, and 3 at debug_bus=4.
